// File: rtl/mux_scan_ctrl_if.sv
// Bus between the scan controller and the downstream 4:1 NAND mux / host.
//
// Handshake: start is a request that is accepted only on a rising edge where
// the controller is idle (busy=0 and done=0); a request seen while busy or
// during the done cycle is dropped, not queued. busy stays high for the whole
// scan, and done is a one-cycle completion strobe. rx_word and mismatch are
// valid from the done cycle until the next scan overwrites them.
interface mux_scan_ctrl_if;
  logic       start;
  logic [3:0] data_in;
  logic       mux_in;
  logic       a;
  logic       b;
  logic       c;
  logic       d;
  logic       s0;
  logic       s1;
  logic       busy;
  logic       done;
  logic [3:0] rx_word;
  logic       mismatch;

  // Controller side.
  modport slave (
    input  start, data_in, mux_in,
    output a, b, c, d, s0, s1, busy, done, rx_word, mismatch
  );

  // Host / environment side.
  modport master (
    output start, data_in, mux_in,
    input  a, b, c, d, s0, s1, busy, done, rx_word, mismatch
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan controller for a 4:1 NAND mux: latches a 4-bit word onto the mux data
// lines, walks the selects over the four channels holding each for HOLD
// cycles, samples the mux output at the end of each hold, and flags whether
// the reassembled word matches the one that was driven.
module mux_scan_ctrl #(
  parameter int HOLD = 1
) (
  input  logic                clk,
  input  logic                rst,
  mux_scan_ctrl_if.slave      bus,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(HOLD - 1);

  state_t     r_state;
  logic       r_a, r_b, r_c, r_d;
  logic       r_s0, r_s1;
  logic       r_busy;
  logic       r_done;
  logic [3:0] r_rx_word;
  logic       r_mismatch;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;

  logic [3:0] w_rx_next;
  logic [1:0] w_idx_next;
  logic [3:0] w_latched;

  assign w_idx_next = r_idx + 2'd1;
  assign w_latched  = {r_d, r_c, r_b, r_a};

  // Received word with the current channel's sample merged in; used both to
  // update rx_word and to compute mismatch on the final sample edge.
  always_comb begin
    w_rx_next        = r_rx_word;
    w_rx_next[r_idx] = bus.mux_in;
  end

  // Scan FSM: all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_c        <= 1'b0;
      r_d        <= 1'b0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rx_word  <= 4'b0000;
      r_mismatch <= 1'b0;
      r_idx      <= 2'd0;
      r_cnt      <= 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.data_in[0];
            r_b     <= bus.data_in[1];
            r_c     <= bus.data_in[2];
            r_d     <= bus.data_in[3];
            r_idx   <= 2'd0;
            r_cnt   <= 4'd0;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (r_cnt == HOLD_LAST) begin
            r_rx_word <= w_rx_next;
            r_cnt     <= 4'd0;
            if (r_idx == 2'd3) begin
              // Last channel sampled: park selects on channel 0 and report.
              r_idx      <= 2'd0;
              r_s0       <= 1'b0;
              r_s1       <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
              r_mismatch <= (w_rx_next != w_latched);
              r_state    <= DONE;
            end else begin
              r_idx <= w_idx_next;
              r_s1  <= w_idx_next[0];
              r_s0  <= w_idx_next[1];
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a        = r_a;
  assign bus.b        = r_b;
  assign bus.c        = r_c;
  assign bus.d        = r_d;
  assign bus.s0       = r_s0;
  assign bus.s1       = r_s1;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.rx_word  = r_rx_word;
  assign bus.mismatch = r_mismatch;
  assign o_dbg_state  = r_state;

endmodule
